// File: rtl/io_channel_responder.sv
// io_channel_responder
//
// Eight-channel I/O responder that sits on a simple core register
// channel. It provides a scratch register, a display output FIFO, a keypad
// input FIFO with an acknowledge channel, a status/sticky-flag channel, a
// synchronised discrete input word, a discrete output latch and an optional
// free-running timer.
//
// Configuration macro: IO_TIMER_EN
//   defined   -> channel 7 is a 15-bit timer advanced every TIMER_DIV clocks
//   undefined -> no timer logic; channel 7 reads zero and ignores writes
//
// Ports:
//   clock          in   1   clock
//   rst_l          in   1   asynchronous active-low reset
//   io_write_en    in   1   channel write strobe
//   io_write_sel   in   3   channel written
//   io_write_data  in  15   write data
//   io_read_sel    in   3   channel read
//   io_read_data   out 15   read data (combinational, no side effects)
//   key_valid      in   1   keypad code offered
//   key_data       in   5   keypad code
//   key_ready      out  1   keyboard FIFO can accept
//   disp_valid     out  1   display word offered
//   disp_data      out 15   display word
//   disp_ready     in   1   display sink accepts
//   discrete_in    in  15   asynchronous discrete inputs
//   discrete_out   out 15   discrete output latch
module io_channel_responder #(
  parameter int KEY_DEPTH  = 4,
  parameter int DISP_DEPTH = 4,
  parameter int TIMER_DIV  = 100
) (
  input  logic        clock,
  input  logic        rst_l,
  input  logic        io_write_en,
  input  logic [2:0]  io_write_sel,
  input  logic [14:0] io_write_data,
  input  logic [2:0]  io_read_sel,
  output logic [14:0] io_read_data,
  input  logic        key_valid,
  input  logic [4:0]  key_data,
  output logic        key_ready,
  output logic        disp_valid,
  output logic [14:0] disp_data,
  input  logic        disp_ready,
  input  logic [14:0] discrete_in,
  output logic [14:0] discrete_out
);

  localparam int KAW = $clog2(KEY_DEPTH);
  localparam int DAW = $clog2(DISP_DEPTH);
  localparam int KCW = KAW + 1;
  localparam int DCW = DAW + 1;

  logic [14:0]    scratch_q;
  logic [14:0]    discreteOut_q;
  logic [14:0]    sync1_q, sync2_q;
  logic           dispDrop_q, dispDrop_d;
  logic           keyOvf_q, keyOvf_d;

  logic [14:0]    dispMem_q [DISP_DEPTH];
  logic [DAW-1:0] dispWr_q, dispRd_q;
  logic [DCW-1:0] dispCnt_q, dispCnt_d;

  logic [4:0]     keyMem_q [KEY_DEPTH];
  logic [KAW-1:0] keyWr_q, keyRd_q;
  logic [KCW-1:0] keyCnt_q, keyCnt_d;

  logic dispFull, dispEmpty, dispPop, dispWrite, dispPush, dispDropSet;
  logic keyFull, keyEmpty, keyPush, keyPop, keyOvfSet, statusWr;
  logic [14:0] timerRead;

  assign dispFull  = (dispCnt_q == DCW'(DISP_DEPTH));
  assign dispEmpty = (dispCnt_q == '0);
  assign keyFull   = (keyCnt_q == KCW'(KEY_DEPTH));
  assign keyEmpty  = (keyCnt_q == '0);

  // A full display FIFO still takes a write when the sink drains the head
  // in the same cycle, so only a full FIFO with no pop drops the word.
  assign dispPop     = !dispEmpty && disp_ready;
  assign dispWrite   = io_write_en && (io_write_sel == 3'd1);
  assign dispPush    = dispWrite && (!dispFull || dispPop);
  assign dispDropSet = dispWrite && !dispPush;

  // Keyboard acceptance looks only at the current fullness; an ack in the
  // same cycle does not make room for a code offered while full.
  assign keyPush   = key_valid && !keyFull;
  assign keyOvfSet = key_valid && keyFull;
  assign keyPop    = io_write_en && (io_write_sel == 3'd3) && !keyEmpty;
  assign statusWr  = io_write_en && (io_write_sel == 3'd4);

  assign key_ready    = !keyFull;
  assign disp_valid   = !dispEmpty;
  assign disp_data    = dispEmpty ? 15'd0 : dispMem_q[dispRd_q];
  assign discrete_out = discreteOut_q;

  // Sticky flags: a set event in the same cycle as its clear wins.
  always_comb begin
    dispCnt_d  = dispCnt_q + DCW'(dispPush) - DCW'(dispPop);
    keyCnt_d   = keyCnt_q + KCW'(keyPush) - KCW'(keyPop);
    dispDrop_d = dispDrop_q;
    keyOvf_d   = keyOvf_q;
    if (statusWr && io_write_data[10]) dispDrop_d = 1'b0;
    if (statusWr && io_write_data[9])  keyOvf_d   = 1'b0;
    if (dispDropSet) dispDrop_d = 1'b1;
    if (keyOvfSet)   keyOvf_d   = 1'b1;
  end

  // Control state; FIFO storage is left unreset since the pointers and
  // counts alone define which entries are live.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      scratch_q     <= '0;
      discreteOut_q <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      dispDrop_q    <= 1'b0;
      keyOvf_q      <= 1'b0;
      dispWr_q      <= '0;
      dispRd_q      <= '0;
      dispCnt_q     <= '0;
      keyWr_q       <= '0;
      keyRd_q       <= '0;
      keyCnt_q      <= '0;
    end else begin
      sync1_q    <= discrete_in;
      sync2_q    <= sync1_q;
      dispDrop_q <= dispDrop_d;
      keyOvf_q   <= keyOvf_d;
      dispCnt_q  <= dispCnt_d;
      keyCnt_q   <= keyCnt_d;
      if (io_write_en && io_write_sel == 3'd0) scratch_q     <= io_write_data;
      if (io_write_en && io_write_sel == 3'd6) discreteOut_q <= io_write_data;
      if (dispPush) dispWr_q <= dispWr_q + 1'b1;
      if (dispPop)  dispRd_q <= dispRd_q + 1'b1;
      if (keyPush)  keyWr_q  <= keyWr_q + 1'b1;
      if (keyPop)   keyRd_q  <= keyRd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (dispPush) dispMem_q[dispWr_q] <= io_write_data;
    if (keyPush)  keyMem_q[keyWr_q]   <= key_data;
  end

`ifdef IO_TIMER_EN
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [PW-1:0] presc_q;
  logic [14:0]   timer_q;
  logic          tick;

  assign tick      = (presc_q == PW'(TIMER_DIV - 1));
  assign timerRead = timer_q;

  // A channel 7 write reloads the timer and restarts the prescaler,
  // overriding any tick that lands in the same cycle.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      presc_q <= '0;
      timer_q <= '0;
    end else if (io_write_en && io_write_sel == 3'd7) begin
      presc_q <= '0;
      timer_q <= io_write_data;
    end else if (tick) begin
      presc_q <= '0;
      timer_q <= timer_q + 15'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end
`else
  assign timerRead = 15'd0;
`endif

  // Read mux is purely combinational so a flushed read leaves no trace.
  always_comb begin
    io_read_data = 15'd0;
    case (io_read_sel)
      3'd0: io_read_data = scratch_q;
      3'd1: io_read_data = {3'(dispCnt_q), 12'd0};
      3'd2: io_read_data = keyEmpty ? 15'd0 : {1'b1, 9'd0, keyMem_q[keyRd_q]};
      3'd3: io_read_data = 15'd0;
      3'd4: io_read_data = {dispFull, dispEmpty, keyFull, keyEmpty,
                            dispDrop_q, keyOvf_q, 9'd0};
      3'd5: io_read_data = sync2_q;
      3'd6: io_read_data = discreteOut_q;
      3'd7: io_read_data = timerRead;
      default: io_read_data = 15'd0;
    endcase
  end

endmodule

// File: tb/tb_io_channel_responder.sv
// tb_io_channel_responder
//
// Self-checking bench for io_channel_responder. A behavioural model built on
// queues tracks the channel state; stimulus pushes expected read data and
// accepted display words into scoreboard queues, and a negedge monitor pops
// and compares them whenever the design presents a read or a display word.
// Works in either build of IO_TIMER_EN.
module tb_io_channel_responder;

  localparam int KD = 4;
  localparam int DD = 4;
  localparam int TD = 4;

  logic        clock = 1'b0;
  logic        rst_l = 1'b0;
  logic        io_write_en = 1'b0;
  logic [2:0]  io_write_sel = 3'd0;
  logic [14:0] io_write_data = 15'd0;
  logic [2:0]  io_read_sel = 3'd0;
  logic [14:0] io_read_data;
  logic        key_valid = 1'b0;
  logic [4:0]  key_data = 5'd0;
  logic        key_ready;
  logic        disp_valid;
  logic [14:0] disp_data;
  logic        disp_ready = 1'b0;
  logic [14:0] discrete_in = 15'd0;
  logic [14:0] discrete_out;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [14:0] mScratch, mDout, mTimer;
  int          mPresc;
  bit          mDrop, mOvf;
  logic [14:0] mDispQ[$];
  logic [4:0]  mKeyQ[$];
  logic [14:0] mDinHist[$];

  // Scoreboard queues
  logic [14:0] dispExpQ[$];
  logic [14:0] rdExpQ[$];
  int          rdSelQ[$];
  bit          rdCheck = 1'b0;

  always #5 clock = ~clock;

  io_channel_responder #(
    .KEY_DEPTH(KD), .DISP_DEPTH(DD), .TIMER_DIV(TD)
  ) dut (
    .clock(clock), .rst_l(rst_l),
    .io_write_en(io_write_en), .io_write_sel(io_write_sel),
    .io_write_data(io_write_data), .io_read_sel(io_read_sel),
    .io_read_data(io_read_data),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
    .discrete_in(discrete_in), .discrete_out(discrete_out)
  );

  // Clear the model the same way a reset clears the hardware.
  function automatic void modelReset();
    mScratch = '0; mDout = '0; mTimer = '0; mPresc = 0;
    mDrop = 0; mOvf = 0;
    mDispQ.delete(); mKeyQ.delete(); dispExpQ.delete();
    mDinHist.delete();
    mDinHist.push_back(15'd0);
    mDinHist.push_back(15'd0);
  endfunction

  // Advance the model by one clock edge from the currently driven inputs.
  function automatic void modelStep();
    bit we = io_write_en;
    int sel = int'(io_write_sel);
    bit dPop = (mDispQ.size() > 0) && disp_ready;
    bit kFull = (mKeyQ.size() == KD);
    bit kPop = we && sel == 3 && mKeyQ.size() > 0;
    if (dPop) void'(mDispQ.pop_front());
    if (we && sel == 1) begin
      if (mDispQ.size() < DD) begin
        mDispQ.push_back(io_write_data);
        dispExpQ.push_back(io_write_data);
      end else mDrop = 1;
    end
    if (kPop) void'(mKeyQ.pop_front());
    if (we && sel == 4) begin
      if (io_write_data[10]) mDrop = 0;
      if (io_write_data[9])  mOvf = 0;
    end
    if (key_valid) begin
      if (kFull) mOvf = 1;
      else mKeyQ.push_back(key_data);
    end
    if (we && sel == 0) mScratch = io_write_data;
    if (we && sel == 6) mDout = io_write_data;
`ifdef IO_TIMER_EN
    if (we && sel == 7) begin
      mTimer = io_write_data;
      mPresc = 0;
    end else begin
      mPresc++;
      if (mPresc == TD) begin
        mPresc = 0;
        mTimer = 15'((int'(mTimer) + 1) % 32768);
      end
    end
`endif
    mDinHist.push_front(discrete_in);
    void'(mDinHist.pop_back());
  endfunction

  always @(posedge clock or negedge rst_l) begin
    if (!rst_l) modelReset();
    else modelStep();
  end

  // Expected read value computed from the model's view of each channel.
  function automatic logic [14:0] expRead(int sel);
    logic [14:0] r = 15'd0;
    case (sel)
      0: r = mScratch;
      1: r = 15'(mDispQ.size() * 4096);
      2: if (mKeyQ.size() > 0) r = 15'h4000 | 15'(mKeyQ[0]);
      4: begin
        if (mDispQ.size() == DD) r |= 15'h4000;
        if (mDispQ.size() == 0)  r |= 15'h2000;
        if (mKeyQ.size() == KD)  r |= 15'h1000;
        if (mKeyQ.size() == 0)   r |= 15'h0800;
        if (mDrop) r |= 15'h0400;
        if (mOvf)  r |= 15'h0200;
      end
      5: r = mDinHist[1];
      6: r = mDout;
`ifdef IO_TIMER_EN
      7: r = mTimer;
`endif
      default: r = 15'd0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(string name, logic [14:0] act, logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compares level outputs every cycle and pops the scoreboards
  // whenever a read is in flight or a display word is handed off.
  always @(negedge clock) begin
    checkOutput("key_ready", 15'(key_ready), 15'(mKeyQ.size() < KD));
    checkOutput("disp_valid", 15'(disp_valid), 15'(mDispQ.size() > 0));
    checkOutput("discrete_out", discrete_out, mDout);
    if (!rst_l) checkOutput("disp_data_in_reset", disp_data, 15'd0);
    if (rst_l && disp_valid && disp_ready) begin
      if (dispExpQ.size() == 0) checkOutput("disp_unexpected", disp_data, 15'h7fff ^ disp_data);
      else checkOutput("disp_data", disp_data, dispExpQ.pop_front());
    end
    if (rdCheck && rdExpQ.size() > 0)
      checkOutput($sformatf("read_ch%0d", rdSelQ.pop_front()), io_read_data, rdExpQ.pop_front());
  end

  // Drive one cycle of stimulus starting just after a rising edge.
  task automatic applyStimulus(bit we, int wsel, logic [14:0] wdata,
                               bit rd, int rsel, bit kv, logic [4:0] kd);
    io_write_en   = we;
    io_write_sel  = 3'(wsel);
    io_write_data = wdata;
    io_read_sel   = 3'(rsel);
    key_valid     = kv;
    key_data      = kd;
    if (rd) begin
      rdExpQ.push_back(expRead(rsel));
      rdSelQ.push_back(rsel);
      rdCheck = 1'b1;
    end
    @(posedge clock);
    #1;
    io_write_en = 1'b0;
    key_valid   = 1'b0;
    rdCheck     = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 15'd0, 0, 0, 0, 5'd0);
  endtask

  task automatic readCh(int sel);
    applyStimulus(0, 0, 15'd0, 1, sel, 0, 5'd0);
  endtask

  task automatic writeCh(int sel, logic [14:0] data);
    applyStimulus(1, sel, data, 0, 0, 0, 5'd0);
  endtask

  task automatic pushKey(logic [4:0] code);
    applyStimulus(0, 0, 15'd0, 0, 0, 1, code);
  endtask

  initial begin
    modelReset();
    // Hold reset across a few edges, then release just after an edge.
    repeat (3) @(posedge clock);
    #1 rst_l = 1'b1;
    @(posedge clock); #1;

    // Post-reset read of every channel
    for (int c = 0; c < 8; c++) readCh(c);

    // Scratch register
    writeCh(0, 15'h2a5c);
    readCh(0);

    // Display FIFO overfill, then drain in order
    disp_ready = 1'b0;
    for (int v = 1; v <= 5; v++) writeCh(1, 15'(v));
    readCh(4);
    readCh(1);
    disp_ready = 1'b1;
    idle(5);
    readCh(4);
    writeCh(4, 15'h0400);
    readCh(4);

    // Full display FIFO with simultaneous push and pop
    disp_ready = 1'b0;
    for (int v = 0; v < 4; v++) writeCh(1, 15'h100 + 15'(v));
    disp_ready = 1'b1;
    writeCh(1, 15'h1ff);
    disp_ready = 1'b0;
    readCh(4);
    disp_ready = 1'b1;
    idle(6);

    // Keyboard FIFO and acknowledge
    pushKey(5'h11);
    pushKey(5'h02);
    readCh(2);
    writeCh(3, 15'd0);
    readCh(2);
    writeCh(3, 15'd0);
    readCh(2);
    writeCh(3, 15'd0);
    for (int k = 0; k < 5; k++) pushKey(5'(k + 3));
    readCh(4);
    writeCh(4, 15'h0200);
    readCh(4);
    for (int k = 0; k < 2; k++) writeCh(3, 15'd0);

    // Two keys held: push and ack together keep the count and advance head
    applyStimulus(1, 3, 15'd0, 0, 0, 1, 5'h1f);
    readCh(2);
    readCh(4);
    for (int k = 0; k < 3; k++) writeCh(3, 15'd0);

    // Discretes: input synchroniser latency and output latch
    discrete_in = 15'h5555;
    for (int k = 0; k < 3; k++) readCh(5);
    writeCh(6, 15'h0f0f);
    readCh(6);

    // Timer load and wrap (reads zero when the timer is not built)
    writeCh(7, 15'h7ffe);
    idle(8);
    readCh(7);
    writeCh(7, 15'h1234);
    readCh(7);

    // Randomised traffic on every channel
    for (int i = 0; i < 400; i++) begin
      disp_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) discrete_in = 15'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    15'($urandom), 1, int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom));
    end

    // Reset in the middle of queued traffic discards everything
    disp_ready = 1'b0;
    writeCh(1, 15'h0abc);
    writeCh(1, 15'h0def);
    pushKey(5'h07);
    rst_l = 1'b0;
    idle(2);
    rst_l = 1'b1;
    @(posedge clock); #1;
    readCh(4);
    readCh(2);
    readCh(1);

    // Drain whatever the display FIFO still holds, within a bounded wait
    writeCh(1, 15'h0777);
    disp_ready = 1'b1;
    for (int b = 0; b < 50 && dispExpQ.size() > 0; b++) idle(1);
    checkOutput("disp_drain", 15'(dispExpQ.size()), 15'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_channel_responder.md
IO_CHANNEL_RESPONDER -- requirements
Module: io_channel_responder

Interface
REQ-001 Parameter KEY_DEPTH, default 4, keyboard FIFO entries (power of 2, at least 2).
REQ-002 Parameter DISP_DEPTH, default 4, display FIFO entries (power of 2, at least 2).
REQ-003 Parameter TIMER_DIV, default 100, clocks per timer tick (at least 1).
REQ-004 Reset rst_l, asynchronous, active-low; clock clock.
REQ-005 Ports, name direction width meaning:
- clock  in  1  clock
- rst_l  in  1  async active-low reset
- io_write_en  in  1  core channel write strobe
- io_write_sel  in  3  channel written
- io_write_data  in  15  write data
- io_read_sel  in  3  channel read
- io_read_data  out  15  read data, combinational
- key_valid  in  1  keypad code offered
- key_data  in  5  keypad code
- key_ready  out  1  keyboard FIFO can accept
- disp_valid  out  1  display word offered
- disp_data  out  15  display word
- disp_ready  in  1  display sink accepts
- discrete_in  in  15  asynchronous discrete inputs
- discrete_out  out  15  discrete output latch

Function
REQ-006 Write effects occur on the clock edge where io_write_en=1 and are visible to reads from the next cycle; reads SHALL have no side effects, since the core may issue a read and then flush it.
REQ-007 Channel 0 (scratch): write loads a 15-bit register; read returns it.
REQ-008 Channel 1 (display): a write pushes io_write_data into the display FIFO. If the FIFO is full, the write is dropped and sticky disp_drop is set. Read returns {DISP count in [14:12], 12'd0}.
REQ-009 Display FIFO: disp_valid = not empty; disp_data = head; pop on disp_valid & disp_ready. A push and a pop in the same cycle while non-empty leaves the count unchanged. When the FIFO is full, a push and a pop in the same cycle SHALL also be accepted.
REQ-010 Keyboard FIFO: key_ready = not full; push key_data on key_valid & key_ready. key_valid while full sets sticky key_ovf; the code is lost.
REQ-011 Channel 2 (key) read: {non-empty in [14], 9'd0, head code in [4:0]}. Read returns 15'd0 when empty.
REQ-012 Channel 3 (key ack): any write pops the keyboard FIFO if it is non-empty, otherwise no effect. A simultaneous push and pop SHALL both occur.
REQ-013 Channel 4 (status) read: [14] disp full, [13] disp empty, [12] key full, [11] key empty, [10] disp_drop, [9] key_ovf, rest 0. Write: bit 10 set clears disp_drop, bit 9 set clears key_ovf. A new set event in the same cycle as its clear wins.
REQ-014 Channel 5 (discretes in): read returns discrete_in passed through a 2-flop synchronizer, latency 2 cycles; writes are ignored.
REQ-015 Channel 6 (discretes out): write loads discrete_out; read returns it.
REQ-016 Channel 7 (timer): see Configuration.
REQ-017 FIFO pointers wrap modulo depth. Counts are width clog2(depth)+1 and SHALL never exceed depth.

Reset
REQ-018 While rst_l=0, all registers clear asynchronously: scratch, discrete_out, timer, prescaler, sticky flags, and both FIFOs, which become empty.
REQ-019 Outputs during reset: key_ready=1, disp_valid=0, disp_data=0, discrete_out=0.
REQ-020 Reset asserted mid-transfer discards all queued data, with no partial state retained.

Configuration
REQ-021 Macro IO_TIMER_EN controls the timer.
- Defined: a prescaler counts 0..TIMER_DIV-1, and each wrap increments a 15-bit timer, which wraps from 77777 octal to 0.
- Defined: channel 7 read returns the timer; a channel 7 write loads it and zeroes the prescaler. A write wins over a same-cycle tick.
- Undefined: no timer or prescaler logic; channel 7 reads 15'd0 and writes are ignored.

Verification
REQ-022 Reset, then read channels 0-7 -> ch4=0x2800 (disp empty, key empty), all others 0; key_ready=1, disp_valid=0.
REQ-023 Write ch1 values 1..5 with disp_ready=0 -> first 4 queued, 5th dropped, ch4 bit14=1 and bit10=1. Raise disp_ready -> 1,2,3,4 emitted in order on consecutive cycles.
REQ-024 Push key codes 5'h11, 5'h02 -> ch2 reads 0x4011. Write ch3 -> ch2 reads 0x4002. Write ch3 again -> ch2 reads 0. Push 5 codes with no ack -> key_ready=0 after 4, key_ovf=1. Write ch4 with 0x0200 -> key_ovf=0.
REQ-025 FIFO holding 2 keys, key_valid and ch3 write in the same cycle -> count stays 2 and the head advances.
REQ-026 With IO_TIMER_EN and TIMER_DIV=4: write ch7=0x7FFE, wait 8 clocks -> reads 0x0000 (wrapped). Without the macro, write ch7=0x1234 -> reads 0.
REQ-027 Toggle discrete_in to 0x5555 -> ch5 reads 0x5555 exactly 2 cycles later. Write ch6=0x0F0F -> discrete_out=0x0F0F on the next cycle.
